// File: rtl/write_port.sv
// Write side of a 32 x 32-bit register file: one committed write per clock, r0 reads as zero.
// Also exports a registered record of the last commit and a saturating commit counter.
module write_port (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  output logic [31:0] q0,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic [31:0] q4,
  output logic [31:0] q5,
  output logic [31:0] q6,
  output logic [31:0] q7,
  output logic [31:0] q8,
  output logic [31:0] q9,
  output logic [31:0] q10,
  output logic [31:0] q11,
  output logic [31:0] q12,
  output logic [31:0] q13,
  output logic [31:0] q14,
  output logic [31:0] q15,
  output logic [31:0] q16,
  output logic [31:0] q17,
  output logic [31:0] q18,
  output logic [31:0] q19,
  output logic [31:0] q20,
  output logic [31:0] q21,
  output logic [31:0] q22,
  output logic [31:0] q23,
  output logic [31:0] q24,
  output logic [31:0] q25,
  output logic [31:0] q26,
  output logic [31:0] q27,
  output logic [31:0] q28,
  output logic [31:0] q29,
  output logic [31:0] q30,
  output logic [31:0] q31,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [15:0] write_count
);

  logic [31:0] w_onehot;
  logic        w_commit;
  logic [31:0] r_regs [1:31];
  logic        r_wb_valid;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic [15:0] r_count;

  // Bit 0 of the decode marks a write to r0, which is dropped.
  always_comb begin
    w_onehot = 32'b1 << ctrl_writeReg;
    w_commit = ctrl_writeEnable && !w_onehot[0] && !ctrl_reset;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_count    <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (ctrl_writeEnable && w_onehot[i]) r_regs[i] <= data_writeReg;
      end
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_wb_reg  <= ctrl_writeReg;
        r_wb_data <= data_writeReg;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign q0  = 32'h0;
  assign q1  = r_regs[1];
  assign q2  = r_regs[2];
  assign q3  = r_regs[3];
  assign q4  = r_regs[4];
  assign q5  = r_regs[5];
  assign q6  = r_regs[6];
  assign q7  = r_regs[7];
  assign q8  = r_regs[8];
  assign q9  = r_regs[9];
  assign q10 = r_regs[10];
  assign q11 = r_regs[11];
  assign q12 = r_regs[12];
  assign q13 = r_regs[13];
  assign q14 = r_regs[14];
  assign q15 = r_regs[15];
  assign q16 = r_regs[16];
  assign q17 = r_regs[17];
  assign q18 = r_regs[18];
  assign q19 = r_regs[19];
  assign q20 = r_regs[20];
  assign q21 = r_regs[21];
  assign q22 = r_regs[22];
  assign q23 = r_regs[23];
  assign q24 = r_regs[24];
  assign q25 = r_regs[25];
  assign q26 = r_regs[26];
  assign q27 = r_regs[27];
  assign q28 = r_regs[28];
  assign q29 = r_regs[29];
  assign q30 = r_regs[30];
  assign q31 = r_regs[31];

  assign wb_valid    = r_wb_valid;
  assign wb_reg      = r_wb_reg;
  assign wb_data     = r_wb_data;
  assign write_count = r_count;

endmodule

// File: tb/tb_write_port.sv
// Randomized scoreboard bench for write_port: the driver predicts post-edge state from the
// register-file rules, and a monitor compares every cycle against the queued prediction.
module tb_write_port;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] q [32];
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [15:0] write_count;

  write_port dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),   .q4(q[4]),   .q5(q[5]),
    .q6(q[6]),   .q7(q[7]),   .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
    .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]), .q16(q[16]), .q17(q[17]),
    .q18(q[18]), .q19(q[19]), .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
    .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]), .q28(q[28]), .q29(q[29]),
    .q30(q[30]), .q31(q[31]),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .write_count(write_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0][31:0] regs;
    logic              v;
    logic [4:0]        r;
    logic [31:0]       d;
    logic [15:0]       c;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   done     = 1'b0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_v;
  logic [4:0]  m_r;
  logic [31:0] m_d;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [4:0] a,
                      input logic [31:0] d);
    exp_t e;
    ctrl_reset       = rst;
    ctrl_writeEnable = en;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_v = 1'b0; m_r = '0; m_d = '0; m_cnt = 0;
    end else if (en && a != 0) begin
      m_regs[a] = d;
      m_v = 1'b1; m_r = a; m_d = d;
      m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_v = 1'b0;
    end
    for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
    e.v = m_v; e.r = m_r; e.d = m_d; e.c = m_cnt[15:0];
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_rand();
    step(1'b0, 1'b0, 5'($urandom), $urandom);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #2;
    if (!done) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < 32; i++) check($sformatf("q%0d", i), q[i], e.regs[i]);
        check("wb_valid", {31'd0, wb_valid}, {31'd0, e.v});
        check("wb_reg", {27'd0, wb_reg}, {27'd0, e.r});
        check("wb_data", wb_data, e.d);
        check("write_count", {16'd0, write_count}, {16'd0, e.c});
      end
    end
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_v = 1'b0; m_r = '0; m_d = '0; m_cnt = 0;

    // Reset with a write request that must be lost, then basic write
    step(1'b1, 1'b1, 5'd3, 32'h1234);
    step(1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle_rand();

    // Register 0 write is dropped
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);

    // Full sweep, then idle with random don't-care inputs
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'h1000_0000 + i);
    for (int i = 0; i < 10; i++) idle_rand();

    // Same-register burst
    step(1'b0, 1'b1, 5'd7, 32'd1);
    step(1'b0, 1'b1, 5'd7, 32'd2);
    step(1'b0, 1'b1, 5'd7, 32'd3);
    idle_rand();

    // Reset vs write collision, then immediate write after reset
    step(1'b1, 1'b1, 5'd9, 32'h55);
    step(1'b0, 1'b1, 5'd9, 32'h66);
    idle_rand();

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 5'($urandom), $urandom);

    // Counter saturation: 65,537 commits from a clean count
    step(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 65537; i++) step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    idle_rand();

    #5;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
